rk_kbd_spi: RTL and testbench



---
 rtl/rk_kbd_spi.sv | 163 ++++++++++++++++
 tb/tb_rk_kbd_spi.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rk_kbd_spi.sv
// SPI-slave keyboard front end: receives RK86 key-matrix frames from the AVR,
// serves PPA port B/C column and modifier data, and issues keyboard resets.
`timescale 1ns/1ps
module rk_kbd_spi #(
   parameter logic [7:0]  VERSION        = 8'h86,
   parameter int unsigned TIMEOUT_CYCLES = 25000000,
   parameter int unsigned RESET_LEN      = 1023
) (
   input  logic       CLK,
   input  logic       N_RESET,
   input  logic       AVR_SCK,
   input  logic       AVR_MOSI,
   input  logic       AVR_SS,
   output logic       AVR_MISO,
   input  logic [7:0] I_ADDR,
   output logic [7:0] o_data,
   output logic [2:0] o_shift,
   output logic       RESET
);

   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned RST_W = (RESET_LEN > 1) ? $clog2(RESET_LEN + 1) : 1;
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_LEN);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t          state;
   logic [2:0]      sck_q;      // [0] meta, [1] synchronised, [2] previous
   logic [2:0]      ss_q;
   logic [1:0]      mosi_q;
   logic [3:0]      bit_cnt;
   logic [7:0]      rx_shift;
   logic [7:0]      tx_shift;
   logic [7:0]      cmd_q;
   logic            commit;
   logic [7:0]      rx_byte;
   logic            sck_rise;
   logic            sck_fall;
   logic            ss_fall;
   logic            ss_rise;
   logic [7:0][7:0] rows;
   logic [TO_W-1:0] to_cnt;
   logic [RST_W-1:0] rst_cnt;

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ss_fall  = ~ss_q[1] & ss_q[2];
   assign ss_rise  = ss_q[1] & ~ss_q[2];
   assign rx_byte  = {rx_shift[6:0], mosi_q[1]};
   assign AVR_MISO = tx_shift[7];

   // Two-flop synchronisers for the AVR SPI pins, plus one history flop for edges
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         sck_q  <= 3'b000;
         ss_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], AVR_SCK};
         ss_q   <= {ss_q[1:0], AVR_SS};
         mosi_q <= {mosi_q[0], AVR_MOSI};
      end
   end

   // Frame FSM: command byte, data byte, one-cycle commit strobe
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         rx_shift <= 8'hFF;
         tx_shift <= 8'h00;
         cmd_q    <= 8'h00;
         commit   <= 1'b0;
      end else begin
         commit <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state    <= CMD;
                  bit_cnt  <= 4'd0;
                  tx_shift <= VERSION;
               end
            end
            CMD, DATA: begin
               if (ss_rise) begin
                  state    <= IDLE;
                  tx_shift <= 8'h00;
               end else begin
                  if (sck_rise) begin
                     rx_shift <= rx_byte;
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (state == CMD && bit_cnt == 4'd7) begin
                        cmd_q <= rx_byte;
                        state <= DATA;
                     end
                     if (state == DATA && bit_cnt == 4'd15) begin
                        commit <= 1'b1;
                        state  <= IDLE;
                     end
                  end
                  if (sck_fall) begin
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Key matrix and modifiers: frame commits and the no-frame timeout release
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         rows    <= {8{8'hFF}};
         o_shift <= 3'b111;
         to_cnt  <= '0;
      end else if (commit) begin
         to_cnt <= '0;
         if (cmd_q >= 8'h01 && cmd_q <= 8'h08) begin
            rows[3'(cmd_q - 8'd1)] <= rx_shift;
         end else if (cmd_q == 8'h09) begin
            o_shift <= rx_shift[2:0];
         end else if (cmd_q == 8'h0B) begin
            rows    <= {8{8'hFF}};
            o_shift <= 3'b111;
         end
      end else if (TIMEOUT_CYCLES != 0 && to_cnt != TO_LIMIT) begin
         to_cnt <= to_cnt + TO_W'(1);
         if (to_cnt == TO_LIMIT - TO_W'(1)) begin
            rows    <= {8{8'hFF}};
            o_shift <= 3'b111;
         end
      end
   end

   // Keyboard-requested system reset pulse, retriggerable
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         rst_cnt <= '0;
         RESET   <= 1'b0;
      end else if (commit && cmd_q == 8'h0A && rx_shift[0]) begin
         rst_cnt <= RST_LOAD;
         RESET   <= (RESET_LEN != 0);
      end else if (rst_cnt != '0) begin
         rst_cnt <= rst_cnt - RST_W'(1);
         if (rst_cnt == RST_W'(1)) begin
            RESET <= 1'b0;
         end
      end
   end

   // Column readout: wired-AND of every row whose strobe is low
   always_comb begin
      o_data = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         if (!I_ADDR[i]) begin
            o_data = o_data & rows[i];
         end
      end
   end

endmodule

// File: tb/tb_rk_kbd_spi.sv
// Randomised self-checking bench for rk_kbd_spi with a behavioural key-matrix model.
`timescale 1ns/1ps
module tb_rk_kbd_spi;

   localparam int unsigned TO_CYC  = 1000;
   localparam int unsigned RST_LEN = 200;
   localparam int          HALF    = 5;

   logic       CLK = 1'b0;
   logic       N_RESET = 1'b0;
   logic       AVR_SCK = 1'b0;
   logic       AVR_MOSI = 1'b0;
   logic       AVR_SS = 1'b1;
   logic       AVR_MISO;
   logic [7:0] I_ADDR = 8'hFF;
   logic [7:0] o_data;
   logic [2:0] o_shift;
   logic       RESET;

   rk_kbd_spi #(
      .VERSION        (8'h86),
      .TIMEOUT_CYCLES (TO_CYC),
      .RESET_LEN      (RST_LEN)
   ) dut (
      .CLK      (CLK),
      .N_RESET  (N_RESET),
      .AVR_SCK  (AVR_SCK),
      .AVR_MOSI (AVR_MOSI),
      .AVR_SS   (AVR_SS),
      .AVR_MISO (AVR_MISO),
      .I_ADDR   (I_ADDR),
      .o_data   (o_data),
      .o_shift  (o_shift),
      .RESET    (RESET)
   );

   always #10 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t16 = 0;
   logic [7:0]  lat_data;
   logic [2:0]  lat_shift;
   logic [7:0]  mrows [8];
   logic [2:0]  mshift;

   // RESET pulse observer
   int   rise_cyc = 0, fall_cyc = 0, fall_cnt = 0;
   logic rst_prev = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (RESET && !rst_prev) rise_cyc = cyc;
      if (!RESET && rst_prev) begin
         fall_cyc = cyc;
         fall_cnt = fall_cnt + 1;
      end
      rst_prev = RESET;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_release();
      for (int i = 0; i < 8; i++) mrows[i] = 8'hFF;
      mshift = 3'b111;
   endtask

   task automatic model_commit(input logic [7:0] c, input logic [7:0] d);
      if (c >= 8'd1 && c <= 8'd8) mrows[c - 8'd1] = d;
      else if (c == 8'h09) mshift = d[2:0];
      else if (c == 8'h0B) model_release();
   endtask

   // A column reads low when any selected row has that key pressed
   function automatic logic [7:0] model_col(input logic [7:0] addr);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) begin
         r[j] = 1'b1;
         for (int i = 0; i < 8; i++)
            if (addr[i] == 1'b0 && mrows[i][j] == 1'b0) r[j] = 1'b0;
      end
      return r;
   endfunction

   task automatic spi_frame(input logic [15:0] word, input int nbits, input bit keep_ss,
                            output logic [15:0] miso);
      miso = 16'h0000;
      AVR_SS = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      for (int b = 0; b < nbits; b++) begin
         AVR_MOSI = word[15 - b];
         repeat (HALF) @(posedge CLK);
         #1;
         AVR_SCK = 1'b1;
         miso[15 - b] = AVR_MISO;
         if (b == 15) begin
            t16 = cyc;
            repeat (4) @(posedge CLK);
            #1;
            lat_data  = o_data;
            lat_shift = o_shift;
            repeat (HALF - 4) @(posedge CLK);
            #1;
         end else begin
            repeat (HALF) @(posedge CLK);
            #1;
         end
         AVR_SCK = 1'b0;
      end
      repeat (4) @(posedge CLK);
      #1;
      if (!keep_ss) begin
         AVR_SS = 1'b1;
         repeat (8) @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(posedge CLK);
      #1;
   endtask

   task automatic wait_fall(input int base, input string tag);
      int n = 0;
      while (fall_cnt == base && n < 2000) begin
         @(posedge CLK);
         n++;
      end
      #1;
      if (fall_cnt == base) check(tag, 32'd0, 32'd1);
   endtask

   initial begin
      logic [15:0] miso;
      logic [7:0]  c, d, a;
      int          nb, base, dur, t1, t2;

      model_release();
      repeat (3) @(posedge CLK);
      #1;
      I_ADDR = 8'h00;
      #1;
      check("rst_data", 32'(o_data), 32'h0FF);
      check("rst_shift", 32'(o_shift), 32'h7);
      check("rst_reset", 32'(RESET), 32'h0);
      check("rst_miso", 32'(AVR_MISO), 32'h0);
      N_RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      // single key, latency and MISO identification
      I_ADDR = 8'hFB;
      spi_frame(16'h03FB, 16, 1'b0, miso);
      model_commit(8'h03, 8'hFB);
      check("lat_data", 32'(lat_data), 32'(model_col(8'hFB)));
      check("miso_id", 32'(miso), 32'h8600);
      I_ADDR = 8'hFE;
      #1;
      check("unsel_row", 32'(o_data), 32'h0FF);

      // wired-AND of two rows
      spi_frame(16'h01FE, 16, 1'b0, miso);
      model_commit(8'h01, 8'hFE);
      spi_frame(16'h02FD, 16, 1'b0, miso);
      model_commit(8'h02, 8'hFD);
      I_ADDR = 8'hFC;
      #1;
      check("wired_and", 32'(o_data), 32'h0FC);
      I_ADDR = 8'hFF;
      #1;
      check("no_strobe", 32'(o_data), 32'h0FF);

      // aborted frame is discarded, next full frame applies
      spi_frame(16'h0100, 11, 1'b0, miso);
      I_ADDR = 8'hFE;
      #1;
      check("abort_row0", 32'(o_data), 32'(model_col(8'hFE)));
      spi_frame(16'h0906, 16, 1'b0, miso);
      model_commit(8'h09, 8'h06);
      check("shift_lat", 32'(lat_shift), 32'h6);
      check("shift", 32'(o_shift), 32'h6);

      // random frames, some aborted, against the model
      for (int k = 0; k < 40; k++) begin
         c = 8'($urandom_range(0, 15));
         if (c == 8'h0A) c = 8'h55;
         d = 8'($urandom);
         nb = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 15) : 16;
         spi_frame({c, d}, nb, 1'b0, miso);
         if (nb == 16) model_commit(c, d);
         a = 8'($urandom);
         I_ADDR = a;
         #1;
         check("rnd_col", 32'(o_data), 32'(model_col(a)));
         a = 8'hFF ^ (8'h01 << $urandom_range(0, 7));
         I_ADDR = a;
         #1;
         check("rnd_row", 32'(o_data), 32'(model_col(a)));
         check("rnd_shift", 32'(o_shift), 32'(mshift));
      end

      // timeout release with no further frames
      spi_frame(16'h057F, 16, 1'b0, miso);
      model_commit(8'h05, 8'h7F);
      spi_frame(16'h0903, 16, 1'b0, miso);
      model_commit(8'h09, 8'h03);
      I_ADDR = 8'hEF;
      base = t16;
      wait_cyc(base + int'(TO_CYC) - 5);
      check("to_before", 32'(o_data), 32'h07F);
      wait_cyc(base + int'(TO_CYC) + 10);
      check("to_after", 32'(o_data), 32'h0FF);
      check("to_shift", 32'(o_shift), 32'h7);
      model_release();

      // reset pulse width
      base = fall_cnt;
      spi_frame(16'h0A01, 16, 1'b0, miso);
      wait_fall(base, "rst_timeout");
      dur = fall_cyc - rise_cyc;
      check("rst_width", 32'(dur >= int'(RST_LEN) && dur <= int'(RST_LEN) + 1), 32'd1);

      // retrigger mid-pulse extends it into one longer pulse
      base = fall_cnt;
      spi_frame(16'h0A01, 16, 1'b0, miso);
      t1 = t16;
      spi_frame(16'h0A01, 16, 1'b0, miso);
      t2 = t16;
      check("ext_high", 32'(RESET), 32'd1);
      wait_fall(base, "ext_timeout");
      check("ext_one", 32'(fall_cnt - base), 32'd1);
      dur = fall_cyc - t2;
      check("ext_end", 32'(dur >= int'(RST_LEN) && dur <= int'(RST_LEN) + 5), 32'd1);
      check("ext_longer", 32'(fall_cyc - t1 > int'(RST_LEN) + 20), 32'd1);

      // N_RESET mid-frame
      spi_frame(16'h0902, 16, 1'b0, miso);
      spi_frame(16'h0800, 16, 1'b0, miso);
      spi_frame(16'h0A01, 16, 1'b0, miso);
      spi_frame(16'h0102, 6, 1'b1, miso);
      check("pre_miso", 32'(AVR_MISO), 32'd1);
      check("pre_reset", 32'(RESET), 32'd1);
      N_RESET = 1'b0;
      I_ADDR = 8'h00;
      #1;
      check("nrst_data", 32'(o_data), 32'h0FF);
      check("nrst_shift", 32'(o_shift), 32'h7);
      check("nrst_reset", 32'(RESET), 32'h0);
      check("nrst_miso", 32'(AVR_MISO), 32'h0);
      AVR_SS = 1'b1;
      AVR_SCK = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      N_RESET = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      model_release();
      spi_frame(16'h0905, 16, 1'b0, miso);
      model_commit(8'h09, 8'h05);
      check("recover_shift", 32'(o_shift), 32'(mshift));
      I_ADDR = 8'h7F;
      #1;
      check("recover_row7", 32'(o_data), 32'(model_col(8'h7F)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
